// File: rtl/pipe_adder_pkg.sv
// -----------------------------------------------------------------------------
// pipe_adder_pkg
// Shared definitions for the pipelined adder/subtractor.
//   SLICE_W : width of one carry-lookahead slice (4 bits)
//   op_e    : operation select encoding (OP_ADD = 0, OP_SUB = 1)
// -----------------------------------------------------------------------------
package pipe_adder_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

endpackage

// File: rtl/pipe_adder_cla_slice.sv
// -----------------------------------------------------------------------------
// cla_slice
// 4-bit carry-lookahead adder slice.
//   a, b : slice operands
//   c0   : carry into bit 0
//   s    : slice sum
//   cout : carry out of bit 3
//   c3   : carry into bit 3 (used by the top slice for signed overflow)
// -----------------------------------------------------------------------------
module cla_slice
    import pipe_adder_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               c0,
    output logic [SLICE_W-1:0] s,
    output logic               cout,
    output logic               c3
);

    logic [SLICE_W-1:0] g;
    logic [SLICE_W-1:0] p;
    logic               c1;
    logic               c2;

    assign g = a & b;
    assign p = a ^ b;

    // Every carry is a flat sum-of-products of g/p and c0, so no carry
    // ripples through the slice.
    assign c1   = g[0] | (p[0] & c0);
    assign c2   = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    assign c3   = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c0);
    assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c0);

    assign s = p ^ {c3, c2, c1, c0};

endmodule

// File: rtl/pipe_adder.sv
// -----------------------------------------------------------------------------
// pipe_adder
// Skewed-pipeline adder/subtractor with valid/ready handshakes on both sides.
// Stage k adds bits [(k+1)*WIDTH/STAGES-1 : k*WIDTH/STAGES] using chained
// 4-bit CLA slices; upper operand bits and finished lower sum bits travel
// with the beat, so every result equals the full-width combinational sum.
// WIDTH must be a multiple of 4*STAGES; STAGES is 1..8.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid, in_ready  : operand handshake
//   a, b, cin, sub      : operands; sub=0 -> a+b+cin, sub=1 -> a-b (cin unused)
//   out_valid, out_ready: result handshake
//   sum, cout, ovf, zero: result, raw MSB carry, signed overflow, sum==0
// -----------------------------------------------------------------------------
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int STAGE_W = WIDTH / STAGES;
    localparam int NSLICE  = WIDTH / SLICE_W;
    localparam int SPS     = STAGE_W / SLICE_W;   // slices per stage

    // Per-stage registered state
    logic             v_q [STAGES];
    logic [WIDTH-1:0] a_q [STAGES];
    logic [WIDTH-1:0] b_q [STAGES];   // already inverted for subtraction
    logic [WIDTH-1:0] s_q [STAGES];
    logic             c_q [STAGES];   // carry out of the stage's top bit

    // Per-stage inputs (from the ports for stage 0, from stage k-1 otherwise)
    logic             v_in   [STAGES];
    logic [WIDTH-1:0] a_in   [STAGES];
    logic [WIDTH-1:0] b_in   [STAGES];
    logic [WIDTH-1:0] s_in   [STAGES];
    logic             c_in   [STAGES];
    logic [WIDTH-1:0] s_next [STAGES];

    // rdy[k] is the ready of stage k; rdy[STAGES] is the consumer
    logic             rdy [STAGES+1];

    logic [WIDTH-1:0] slice_sum;
    logic             slice_c0 [NSLICE];
    logic             slice_co [NSLICE];
    logic             slice_c3 [NSLICE];

    logic             ovf_q;
    logic             zero_q;
    op_e              op;

    assign op          = op_e'(sub);
    assign rdy[STAGES] = out_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam logic [WIDTH-1:0] ONES = '1;
        localparam logic [WIDTH-1:0] MASK = (ONES >> (WIDTH - STAGE_W)) << (k * STAGE_W);

        if (k == 0) begin : g_head
            // Subtraction is a + ~b + 1: invert b once here, and force the
            // carry-in to 1 so cin is ignored.
            assign v_in[k] = in_valid;
            assign a_in[k] = a;
            assign b_in[k] = (op == OP_SUB) ? ~b : b;
            assign c_in[k] = (op == OP_SUB) ? 1'b1 : cin;
            assign s_in[k] = '0;
        end else begin : g_body
            assign v_in[k] = v_q[k-1];
            assign a_in[k] = a_q[k-1];
            assign b_in[k] = b_q[k-1];
            assign c_in[k] = c_q[k-1];
            assign s_in[k] = s_q[k-1];
        end

        // A stage can take a beat if it is empty or its occupant moves on
        // this same edge; the chain is combinational so bubbles collapse.
        assign rdy[k] = !v_q[k] || rdy[k+1];

        // Keep the lower bits finished by earlier stages, splice in this
        // stage's slice results.
        assign s_next[k] = (s_in[k] & ~MASK) | (slice_sum & MASK);

        // NOTE: sequential state uses non-blocking assignments so every
        // stage samples its upstream neighbour's pre-edge value.
        // NOTE: datapath registers are reset as well as the valids, so the
        // result outputs read zero while in reset.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q[k] <= 1'b0;
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
                c_q[k] <= 1'b0;
            end else if (rdy[k]) begin
                v_q[k] <= v_in[k];
                a_q[k] <= a_in[k];
                b_q[k] <= b_in[k];
                s_q[k] <= s_next[k];
                c_q[k] <= slice_co[(k+1)*SPS-1];
            end
        end
    end

    for (genvar j = 0; j < NSLICE; j++) begin : g_slice
        localparam int K = j / SPS;   // stage that owns this slice

        if ((j % SPS) == 0) begin : g_first
            assign slice_c0[j] = c_in[K];
        end else begin : g_chain
            assign slice_c0[j] = slice_co[j-1];
        end

        cla_slice u_cla (
            .a    (a_in[K][SLICE_W*j +: SLICE_W]),
            .b    (b_in[K][SLICE_W*j +: SLICE_W]),
            .c0   (slice_c0[j]),
            .s    (slice_sum[SLICE_W*j +: SLICE_W]),
            .cout (slice_co[j]),
            .c3   (slice_c3[j])
        );
    end

    // Flags only exist for the final sum, so they are registered alongside
    // the last stage with the same enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (rdy[STAGES-1]) begin
            ovf_q  <= slice_c3[NSLICE-1] ^ slice_co[NSLICE-1];
            zero_q <= (s_next[STAGES-1] == '0);
        end
    end

    assign in_ready  = rdy[0];
    assign out_valid = v_q[STAGES-1];
    assign sum       = s_q[STAGES-1];
    assign cout      = c_q[STAGES-1];
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_pipe_adder.sv
// -----------------------------------------------------------------------------
// tb_pipe_adder
// Self-checking bench for pipe_adder (WIDTH=32, STAGES=2): directed corner
// cases, a random stream through a stalled and then released pipeline, and
// reset with beats in flight. Expected results come from a signed/unsigned
// arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_pipe_adder;

    localparam int WIDTH  = 32;
    localparam int STAGES = 2;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b1;
    logic             in_valid  = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a         = '0;
    logic [WIDTH-1:0] b         = '0;
    logic             cin       = 1'b0;
    logic             sub       = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
        logic             zero;
    } res_t;

    always #5 clk = ~clk;

    pipe_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero)
    );

    // Reference: unsigned result for sum/cout, signed result for overflow.
    function automatic res_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                   input logic ci, input logic s);
        res_t   r;
        longint ux = longint'(x);
        longint uy = longint'(y);
        longint sx = longint'($signed(x));
        longint sy = longint'($signed(y));
        longint us;
        longint ss;
        if (s) begin
            us     = ux - uy;
            ss     = sx - sy;
            r.cout = (ux >= uy);          // no borrow
        end else begin
            us     = ux + uy + longint'(ci);
            ss     = sx + sy + longint'(ci);
            r.cout = (us >= 64'sd4294967296);
        end
        r.sum  = us[WIDTH-1:0];
        r.ovf  = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
        r.zero = (r.sum == '0);
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input res_t e);
        check({tag, ".sum"},  sum,  e.sum);
        check({tag, ".cout"}, {31'd0, cout}, {31'd0, e.cout});
        check({tag, ".ovf"},  {31'd0, ovf},  {31'd0, e.ovf});
        check({tag, ".zero"}, {31'd0, zero}, {31'd0, e.zero});
    endtask

    // One beat through an otherwise empty pipeline: checks latency and result.
    task automatic run_beat(input string tag, input logic [WIDTH-1:0] x,
                            input logic [WIDTH-1:0] y, input logic ci, input logic s);
        res_t e;
        int   lat;
        e        = model(x, y, ci, s);
        a        = x;
        b        = y;
        cin      = ci;
        sub      = s;
        in_valid = 1'b1;
        #1;
        check({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat      = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, ".latency"}, lat, STAGES);
        check_out(tag, e);
        @(posedge clk); #1;
    endtask

    res_t             exp_q [$];
    logic [WIDTH-1:0] sa [10];
    logic [WIDTH-1:0] sb [10];
    logic             sc [10];
    logic             ss [10];

    initial begin
        int   acc;
        int   got;
        int   ncyc;
        logic accept;
        logic held_set;
        res_t held;
        res_t e;

        // ---- reset state, in_ready independent of out_ready ----
        out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #10;
        check("rst.out_valid", {31'd0, out_valid}, 32'd0);
        check("rst.in_ready",  {31'd0, in_ready},  32'd1);
        check("rst.sum",       sum, 32'd0);
        check("rst.cout",      {31'd0, cout}, 32'd0);
        check("rst.ovf",       {31'd0, ovf},  32'd0);
        check("rst.zero",      {31'd0, zero}, 32'd0);
        out_ready = 1'b1;
        #1;
        check("rst.in_ready_or", {31'd0, in_ready}, 32'd1);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // ---- directed corner cases ----
        run_beat("wrap",      32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        run_beat("ovf_pos",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        run_beat("boundary",  32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        run_beat("sub_neg",   32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1);
        run_beat("sub_pos",   32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1);
        run_beat("cin_add",   32'h1234_FFFF, 32'h0000_0000, 1'b1, 1'b0);
        run_beat("sub_cin",   32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1);
        run_beat("ovf_neg",   32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);

        // ---- random stream: stall, then release ----
        for (int i = 0; i < 10; i++) begin
            sa[i] = $urandom;
            sb[i] = $urandom;
            sc[i] = 1'($urandom_range(0, 1));
            ss[i] = 1'($urandom_range(0, 1));
        end
        acc       = 0;
        got       = 0;
        held_set  = 1'b0;
        out_ready = 1'b0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            if (acc < 10) begin
                a = sa[acc]; b = sb[acc]; cin = sc[acc]; sub = ss[acc];
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid) begin
                if (!held_set) begin
                    held     = {sum, cout, ovf, zero};
                    held_set = 1'b1;
                end else begin
                    check_out("stall.hold", held);
                end
            end
            accept = in_valid && in_ready;
            @(posedge clk); #1;
            if (accept) begin
                exp_q.push_back(model(sa[acc], sb[acc], sc[acc], ss[acc]));
                acc++;
            end
        end
        check("stall.accepted", acc, STAGES);
        check("stall.in_ready", {31'd0, in_ready}, 32'd0);
        check("stall.out_valid", {31'd0, out_valid}, 32'd1);

        out_ready = 1'b1;
        #1;
        check("full.in_ready", {31'd0, in_ready}, 32'd1);
        ncyc = 0;
        for (int cyc = 0; cyc < 100 && got < 10; cyc++) begin
            if (acc < 10) begin
                a = sa[acc]; b = sb[acc]; cin = sc[acc]; sub = ss[acc];
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            accept = in_valid && in_ready;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL stream.extra: observed unexpected beat sum=%h expected none", sum);
                end else begin
                    e = exp_q.pop_front();
                    check_out($sformatf("beat%0d", got), e);
                end
                got++;
            end
            @(posedge clk); #1;
            ncyc++;
            if (accept) begin
                exp_q.push_back(model(sa[acc], sb[acc], sc[acc], ss[acc]));
                acc++;
            end
        end
        in_valid = 1'b0;
        check("stream.count",  got,  10);
        check("stream.cycles", ncyc, 10);
        check("stream.drain",  exp_q.size(), 0);

        // ---- reset with two beats in flight ----
        a = 32'h0000_0011; b = 32'h0000_0022; cin = 1'b0; sub = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        a = 32'h0000_0033; b = 32'h0000_0044;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("inflight.out_valid", {31'd0, out_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst.out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst.in_ready",  {31'd0, in_ready},  32'd1);
        check("midrst.sum",       sum, 32'd0);
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check($sformatf("post_rst.idle%0d", i), {31'd0, out_valid}, 32'd0);
        end
        run_beat("post_rst", 32'hDEAD_BEEF, 32'h1111_1111, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
